opb_slave_window_ctrl: RTL
==========================

Name: opb_slave_window_ctrl

Overview:
- Sequences OPB access to a bank of C_NUM_SLAVES software-register slaves, for example simulink2ppc register cores.
- The slaves sit in contiguous 256-byte windows starting at C_BASEADDR.
- The block decodes the address, gates OPB_select to exactly one slave, and registers that slave's response back onto the OR-bus.
- A per-transfer timeout returns an error acknowledge when a slave fails to acknowledge, so a stalled slave cannot hang the PowerPC.

Parameters:
- C_BASEADDR, 32'h01008000, base address of window 0.
- C_NUM_SLAVES, 4, number of slave windows (1..16).
- C_WIN_AWIDTH, 8, log2 of window size in bytes.
- C_TIMEOUT, 16, cycles allowed for a slave acknowledge (2..255).

Ports:
- OPB_Clk  in  1  bus clock.
- OPB_Rst_n  in  1  asynchronous reset, active-low.
- OPB_ABus  in  [0:31]  address.
- OPB_RNW  in  1  read/not-write; used only for status capture.
- OPB_select  in  1  master select.
- OPB_seqAddr  in  1  sequential address hint; ignored, each beat is handled as a single transfer.
- slv_select  out  [C_NUM_SLAVES-1:0]  gated select, one-hot or zero.
- slv_DBus  in  [0:32*C_NUM_SLAVES-1]  slave read data; slave i occupies bits 32i..32i+31.
- slv_xferAck  in  [C_NUM_SLAVES-1:0]  per-slave transfer acknowledge.
- slv_errAck  in  [C_NUM_SLAVES-1:0]  per-slave error acknowledge.
- slv_retry  in  [C_NUM_SLAVES-1:0]  per-slave retry.
- slv_toutSup  in  [C_NUM_SLAVES-1:0]  per-slave timeout suppress.
- Sl_DBus  out  [0:31]  read data to OPB.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck  out  1  error acknowledge.
- Sl_retry  out  1  retry.
- Sl_toutSup  out  1  timeout suppress.
- tout_count  out  16  saturating count of timeouts.
- tout_addr  out  32  address of the last timed-out transfer.
- tout_rnw  out  1  RNW of the last timed-out transfer.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (OPB_Rst_n). All outputs are 0 during reset. State is IDLE and the internal counter is 0.
- Window hit: OPB_ABus[0:31-C_WIN_AWIDTH] equals C_BASEADDR upper bits plus idx, with idx < C_NUM_SLAVES.
- An out-of-range address gets no response; the OPB arbiter's timeout handles it.
- IDLE:
  - On OPB_select=1 with a window hit, latch idx, the address and RNW.
  - Clear the counter and go to ACTIVE.
  - slv_select stays 0 in IDLE.
- ACTIVE:
  - slv_select[idx] = OPB_select; all other bits are 0.
  - The counter increments each cycle unless slv_toutSup[idx]=1, in which case it holds.
  - Sl_toutSup = registered slv_toutSup[idx].
- Response register: when slv_xferAck[idx], slv_errAck[idx] or slv_retry[idx] is 1 in ACTIVE:
  - Next cycle, drive Sl_xferAck, Sl_errAck and Sl_retry with the captured values for exactly one cycle.
  - Drive Sl_DBus = slv_DBus[idx] if RNW=1, else 0.
  - Go to DONE. Latency is slave acknowledge + 1 cycle.
- Timeout:
  - Triggers when the counter reaches C_TIMEOUT-1 with no slave acknowledge in that cycle and slv_toutSup[idx]=0.
  - Next cycle: Sl_errAck=1 and Sl_xferAck=1 for one cycle, Sl_DBus=0.
  - tout_count increments, saturating at 16'hFFFF; tout_addr and tout_rnw capture the transfer.
  - Go to DONE.
- Simultaneous acknowledge and timeout in the same cycle: the acknowledge wins and no timeout is logged.
- DONE: slv_select=0 for one cycle, so the slave never sees a phantom second beat. Then go to IDLE, where a back-to-back select is accepted the following cycle.
- Abort: OPB_select=0 while in ACTIVE means return to IDLE next cycle with no acknowledge and no timeout logged. Late slave acknowledges are ignored outside ACTIVE.
- OR-bus rule: Sl_DBus is 0 in every cycle where Sl_xferAck=0. Sl_* are 0 in IDLE and DONE except the one-cycle response.
- Reset mid-transfer: asynchronous return to IDLE; all outputs are 0 immediately.

Test Plan:
- Read window 2: address 0x01008204, slave 2 acknowledges 3 cycles after select with data 0xDEADBEEF. Sl_xferAck pulses one cycle, 1 cycle after the slave acknowledge, with Sl_DBus=0xDEADBEEF. slv_select=4'b0100 until the acknowledge, then 0 for one cycle.
- Write window 0: slave acknowledges immediately. Sl_xferAck pulses for 1 cycle, Sl_DBus stays 0, and the next transfer is accepted 2 cycles after the acknowledge.
- Timeout: slave 1 never acknowledges, C_TIMEOUT=16. Sl_errAck=Sl_xferAck=1 at cycle 17 after select; tout_count=1, tout_addr=0x01008100, tout_rnw=1.
- toutSup: slave 3 holds toutSup for 40 cycles, then acknowledges. No timeout occurs, Sl_toutSup mirrors toutSup delayed 1 cycle, and a normal acknowledge follows.
- Edge cases:
  - Out-of-range address 0x01008400 with 4 slaves: no slv_select and no Sl_* activity.
  - Acknowledge on the same cycle as the timeout: normal acknowledge, tout_count unchanged.
- Abort and reset: OPB_select dropped at ACTIVE cycle 5 means no acknowledge and IDLE next cycle. OPB_Rst_n low mid-ACTIVE means all outputs go to 0 asynchronously and tout_count is cleared.

Source files
------------

// File: rtl/opb_slave_window_ctrl.sv
// OPB front end for a bank of register slaves in contiguous address windows.
// Decodes the window, gates select to one slave, registers its response and times out stalled slaves.
module opb_slave_window_ctrl #(
    parameter logic [31:0] C_BASEADDR   = 32'h01008000,
    parameter int          C_NUM_SLAVES = 4,
    parameter int          C_WIN_AWIDTH = 8,
    parameter int          C_TIMEOUT    = 16
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic [31:0]                 OPB_ABus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [C_NUM_SLAVES-1:0]     slv_select,
    input  logic [32*C_NUM_SLAVES-1:0]  slv_DBus,
    input  logic [C_NUM_SLAVES-1:0]     slv_xferAck,
    input  logic [C_NUM_SLAVES-1:0]     slv_errAck,
    input  logic [C_NUM_SLAVES-1:0]     slv_retry,
    input  logic [C_NUM_SLAVES-1:0]     slv_toutSup,
    output logic [31:0]                 Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic [15:0]                 tout_count,
    output logic [31:0]                 tout_addr,
    output logic                        tout_rnw
);

    localparam int              IW        = (C_NUM_SLAVES > 1) ? $clog2(C_NUM_SLAVES) : 1;
    localparam int              HW        = 32 - C_WIN_AWIDTH;
    localparam logic [HW-1:0]   BASE_HI   = C_BASEADDR[31:C_WIN_AWIDTH];
    localparam logic [HW-1:0]   NUM_HI    = HW'(C_NUM_SLAVES);
    localparam logic [7:0]      TOUT_LAST = 8'(C_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   win_off;
    logic            win_hit;
    logic            accept;
    logic [IW-1:0]   idx;
    logic [31:0]     addr_q;
    logic            rnw_q;
    logic [7:0]      cnt;

    logic            cur_xfer, cur_err, cur_retry, cur_sup;
    logic [31:0]     cur_data;
    logic            active, ack_raw, any_ack, tout_hit;

    // Each beat is a single transfer, so the sequential hint carries no information.
    logic            unused_ok;
    assign unused_ok = OPB_seqAddr;

    // A window index below the base wraps to a large offset and misses as well.
    assign win_off = OPB_ABus[31:C_WIN_AWIDTH] - BASE_HI;
    assign win_hit = (win_off < NUM_HI);
    assign accept  = (state == IDLE) && OPB_select && win_hit;

    // The data bus is big-endian: slave 0 owns the most significant word.
    always_comb begin
        cur_xfer  = 1'b0;
        cur_err   = 1'b0;
        cur_retry = 1'b0;
        cur_sup   = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < C_NUM_SLAVES; i++) begin
            if (idx == IW'(i)) begin
                cur_xfer  = slv_xferAck[i];
                cur_err   = slv_errAck[i];
                cur_retry = slv_retry[i];
                cur_sup   = slv_toutSup[i];
                cur_data  = slv_DBus[32*(C_NUM_SLAVES-1-i) +: 32];
            end
        end
    end

    assign active   = (state == ACTIVE);
    assign ack_raw  = cur_xfer | cur_err | cur_retry;
    assign any_ack  = active & OPB_select & ack_raw;
    // An acknowledge in the terminal cycle beats the timeout.
    assign tout_hit = active & OPB_select & ~ack_raw & ~cur_sup & (cnt == TOUT_LAST);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACTIVE;
            ACTIVE: begin
                if (!OPB_select)            state_nxt = IDLE;
                else if (any_ack | tout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        slv_select = '0;
        for (int i = 0; i < C_NUM_SLAVES; i++)
            slv_select[i] = active && OPB_select && (idx == IW'(i));
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            idx    <= '0;
            addr_q <= '0;
            rnw_q  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            idx    <= win_off[IW-1:0];
            addr_q <= OPB_ABus;
            rnw_q  <= OPB_RNW;
            cnt    <= '0;
        end else if (active && !cur_sup) begin
            cnt    <= cnt + 8'd1;
        end
    end

    // Response register: one-cycle pulse, data forced to zero unless a read is acknowledged.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            Sl_xferAck <= 1'b0;
            Sl_errAck  <= 1'b0;
            Sl_retry   <= 1'b0;
            Sl_toutSup <= 1'b0;
            Sl_DBus    <= '0;
        end else begin
            Sl_xferAck <= (any_ack & cur_xfer) | tout_hit;
            Sl_errAck  <= (any_ack & cur_err) | tout_hit;
            Sl_retry   <= any_ack & cur_retry;
            Sl_toutSup <= active & OPB_select & ~ack_raw & cur_sup;
            Sl_DBus    <= (any_ack & cur_xfer & rnw_q) ? cur_data : 32'h0;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            tout_count <= '0;
            tout_addr  <= '0;
            tout_rnw   <= 1'b0;
        end else if (tout_hit) begin
            if (tout_count != 16'hFFFF) tout_count <= tout_count + 16'd1;
            tout_addr <= addr_q;
            tout_rnw  <= rnw_q;
        end
    end

endmodule
